// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-port memory bus arbiter.
// Owner tags travel through the outstanding-read FIFO.
package mem_bus_pkg;

  localparam int XLEN = 32;
  localparam int SLEN = XLEN / 8;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   drop;
  } owner_entry_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Request/response bundle between the core ports,
// the arbiter and the memory fabric.
interface mem_bus_arbiter_if;
  import mem_bus_pkg::*;

  logic            ireq_valid;
  logic            ireq_ready;
  logic [XLEN-1:0] ireq_addr;
  logic            iflush;
  logic            irvalid;
  logic [XLEN-1:0] irdata;

  logic            dreq_valid;
  logic            dreq_ready;
  logic            dreq_write;
  logic [XLEN-1:0] dreq_addr;
  logic [XLEN-1:0] dreq_wdata;
  logic [SLEN-1:0] dreq_wstrb;
  logic            dram_rvalid;
  logic [XLEN-1:0] dram_rdata;

  logic            bus_req;
  logic            bus_ready;
  logic            bus_write;
  logic [XLEN-1:0] bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic [SLEN-1:0] bus_wstrb;
  logic            bus_rvalid;
  logic [XLEN-1:0] bus_rdata;

  modport master (
    output ireq_valid, ireq_addr, iflush,
    output dreq_valid, dreq_write, dreq_addr,
    output dreq_wdata, dreq_wstrb,
    output bus_ready, bus_rvalid, bus_rdata,
    input  ireq_ready, irvalid, irdata,
    input  dreq_ready, dram_rvalid, dram_rdata,
    input  bus_req, bus_write, bus_addr,
    input  bus_wdata, bus_wstrb
  );

  modport slave (
    input  ireq_valid, ireq_addr, iflush,
    input  dreq_valid, dreq_write, dreq_addr,
    input  dreq_wdata, dreq_wstrb,
    input  bus_ready, bus_rvalid, bus_rdata,
    output ireq_ready, irvalid, irdata,
    output dreq_ready, dram_rvalid, dram_rdata,
    output bus_req, bus_write, bus_addr,
    output bus_wdata, bus_wstrb
  );

endinterface

// File: rtl/mem_bus_arbiter_owner_fifo.sv
// In-order owner tags for reads in flight on the bus,
// with a broadcast mark that kills pending I entries.
module owner_fifo
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         push_i,
  input  owner_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         full_o,
  output logic         empty_o,
  output owner_entry_t head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  owner_entry_t  mem_q [DEPTH];
  owner_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == FULL);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (flush_i && mem_q[k].owner == OWN_I)
        mem_d[k].drop = 1'b1;
    end
    if (do_push) begin
      mem_d[wr_q] = push_entry_i;
      if (flush_i && push_entry_i.owner == OWN_I)
        mem_d[wr_q].drop = 1'b1;
    end
  end

  assign wr_d = !do_push ? wr_q :
                (wr_q == LAST) ? '0 : wr_q + 1'b1;
  assign rd_d = !do_pop ? rd_q :
                (rd_q == LAST) ? '0 : rd_q + 1'b1;
  assign cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter of IF and MEM onto one bus,
// routing in-order read responses back to their owner.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int OST_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_b,
  mem_bus_arbiter_if.slave   mb
);

  owner_e       last_q, last_d;
  owner_entry_t head, push_entry;
  logic         full, empty;
  logic         i_elig, d_elig, win_d;
  logic         req, hs, push, pop;

  assign i_elig = rst_b & mb.ireq_valid & ~full;
  assign d_elig = rst_b & mb.dreq_valid
                & (mb.dreq_write | ~full);

  // On contention the side opposite the last grant wins.
  assign win_d = d_elig & (~i_elig | (last_q == OWN_I));
  assign req   = i_elig | d_elig;
  assign hs    = req & mb.bus_ready;

  assign mb.bus_req   = req;
  assign mb.bus_write = win_d & mb.dreq_write;
  assign mb.bus_addr  = win_d ? mb.dreq_addr : mb.ireq_addr;
  assign mb.bus_wdata = win_d ? mb.dreq_wdata : '0;
  assign mb.bus_wstrb = win_d ? mb.dreq_wstrb : '0;

  assign mb.ireq_ready = i_elig & ~win_d & mb.bus_ready;
  assign mb.dreq_ready = win_d & mb.bus_ready;

  assign push       = hs & ~mb.bus_write;
  assign push_entry = '{owner: win_d ? OWN_D : OWN_I,
                        drop:  1'b0};
  assign pop        = rst_b & mb.bus_rvalid;

  assign last_d = hs ? (win_d ? OWN_D : OWN_I) : last_q;

  always_ff @(posedge clk) begin
    if (!rst_b) last_q <= OWN_I;
    else        last_q <= last_d;
  end

  owner_fifo #(
    .DEPTH (OST_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_b        (rst_b),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (mb.iflush),
    .full_o       (full),
    .empty_o      (empty),
    .head_o       (head)
  );

  assign mb.irvalid = pop & ~empty & ~mb.iflush
                    & (head.owner == OWN_I) & ~head.drop;
  assign mb.dram_rvalid = pop & ~empty
                        & (head.owner == OWN_D);
  assign mb.irdata     = mb.bus_rdata;
  assign mb.dram_rdata = mb.bus_rdata;

  a_rvalid_owned: assert property (
    @(posedge clk) disable iff (!rst_b)
    mb.bus_rvalid |-> !empty
  ) else $error("bus_rvalid with no outstanding read");

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios then
// random traffic against a queue-based reference model.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if mb();

  mem_bus_arbiter #(
    .OST_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .mb    (mb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: outstanding reads in issue order (1 = data).
  bit q_d[$];
  bit q_drop[$];
  bit last_was_d = 1'b0;

  logic        obs_ir, obs_dr, obs_irv, obs_drv;
  logic [31:0] obs_addr, first_addr;
  logic [3:0]  obs_wstrb;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step(bit rst, bit iv, logic [31:0] ia,
                      bit fl, bit dv, bit dw,
                      logic [31:0] da, logic [31:0] dwd,
                      logic [3:0] st, bit br, bit rv,
                      logic [31:0] rd);
    bit full, ie, de, req, wd, hd, hdrop;
    bit exp_irv, exp_drv;
    rst_b         = rst;
    mb.ireq_valid = iv;
    mb.ireq_addr  = ia;
    mb.iflush     = fl;
    mb.dreq_valid = dv;
    mb.dreq_write = dw;
    mb.dreq_addr  = da;
    mb.dreq_wdata = dwd;
    mb.dreq_wstrb = st;
    mb.bus_ready  = br;
    mb.bus_rvalid = rv;
    mb.bus_rdata  = rd;
    #2;
    full = (q_d.size() >= DEPTH);
    ie   = rst && iv && !full;
    de   = rst && dv && (dw || !full);
    req  = ie || de;
    wd   = de && (!ie || !last_was_d);
    exp_irv = 1'b0;
    exp_drv = 1'b0;
    if (rst && rv && q_d.size() > 0) begin
      hd      = q_d.pop_front();
      hdrop   = q_drop.pop_front();
      exp_drv = hd;
      exp_irv = !hd && !hdrop && !fl;
    end
    check("bus_req", mb.bus_req, req);
    check("ireq_ready", mb.ireq_ready, req && !wd && br);
    check("dreq_ready", mb.dreq_ready, wd && br);
    if (req) begin
      check("bus_addr", mb.bus_addr, wd ? da : ia);
      check("bus_write", mb.bus_write, wd && dw);
      check("bus_wstrb", mb.bus_wstrb, wd ? st : 4'h0);
      if (wd) check("bus_wdata", mb.bus_wdata, dwd);
    end
    check("irvalid", mb.irvalid, exp_irv);
    check("dram_rvalid", mb.dram_rvalid, exp_drv);
    check("irdata", mb.irdata, rd);
    check("dram_rdata", mb.dram_rdata, rd);
    obs_ir    = mb.ireq_ready;
    obs_dr    = mb.dreq_ready;
    obs_irv   = mb.irvalid;
    obs_drv   = mb.dram_rvalid;
    obs_addr  = mb.bus_addr;
    obs_wstrb = mb.bus_wstrb;
    if (!rst) begin
      q_d.delete();
      q_drop.delete();
      last_was_d = 1'b0;
    end else begin
      if (fl) begin
        foreach (q_d[k]) if (!q_d[k]) q_drop[k] = 1'b1;
      end
      if (req && br) begin
        if (!(wd && dw)) begin
          q_d.push_back(wd);
          q_drop.push_back(fl && !wd);
        end
        last_was_d = wd;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic i_rd(logic [31:0] a);
    step(1, 1, a, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic d_rd(logic [31:0] a);
    step(1, 0, 0, 0, 1, 0, a, 0, 4'hF, 1, 0, 0);
  endtask

  task automatic resp(logic [31:0] d);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, d);
  endtask

  initial begin
    // Reset: everything quiet despite live requests.
    for (int k = 0; k < 2; k++)
      step(0, 1, 'h10, 0, 1, 0, 'h20, 0, 4'hF, 1, 0, 0);

    // Contention from reset: D, I, D, I.
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 32'h300 + 32'(k * 4), 0, 1, 0,
           32'h400 + 32'(k * 4), 0, 4'hF, 1,
           k > 0, 32'h5000 + 32'(k));
      check("cont_d", obs_dr, (k % 2) == 0);
      check("cont_i", obs_ir, (k % 2) == 1);
    end
    resp('h5004);

    // Solo traffic.
    i_rd('h100);
    check("solo_addr_i", obs_addr, 'h100);
    d_rd('h200);
    check("solo_addr_d", obs_addr, 'h200);
    resp('hAAAA);
    check("solo_irv", obs_irv, 1);
    resp('hBBBB);
    check("solo_drv", obs_drv, 1);

    // Full: third read stalls, a write still goes.
    i_rd('h110);
    d_rd('h210);
    step(1, 1, 'h118, 0, 1, 1, 'h220, 'hDEAD, 4'hF,
         1, 0, 0);
    check("full_iready", obs_ir, 0);
    check("full_wr", obs_dr, 1);
    check("full_wstrb", obs_wstrb, 4'hF);
    step(1, 1, 'h118, 0, 0, 0, 0, 0, 0, 1, 1, 'h11);
    check("full_pop_iready", obs_ir, 0);
    i_rd('h118);
    check("full_after", obs_ir, 1);
    resp('h12);
    resp('h13);

    // Flush drops the pending I response only.
    i_rd('h120);
    d_rd('h230);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    resp('hCC);
    check("flush_irv", obs_irv, 0);
    resp('hDD);
    check("flush_drv", obs_drv, 1);

    // Backpressure: no grant, stable address.
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 'h130, 0, 1, 0, 'h240, 0, 4'hF,
           0, 0, 0);
      if (k == 0) first_addr = obs_addr;
      check("bp_iready", obs_ir, 0);
      check("bp_dready", obs_dr, 0);
      check("bp_addr", obs_addr, first_addr);
    end
    step(1, 1, 'h130, 0, 1, 0, 'h240, 0, 4'hF, 1, 0, 0);
    check("bp_last", obs_ir, 1);
    resp('hEE);

    // Reset mid-flight empties the FIFO.
    i_rd('h140);
    d_rd('h250);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    i_rd('h144);
    check("rst_rd0", obs_ir, 1);
    d_rd('h254);
    check("rst_rd1", obs_dr, 1);
    i_rd('h148);
    check("rst_full", obs_ir, 0);
    resp('h21);
    resp('h22);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      step(1, 1'($urandom_range(0, 1)), $urandom,
           $urandom_range(0, 7) == 0,
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom, $urandom,
           4'($urandom), $urandom_range(0, 3) != 0,
           (q_d.size() > 0) && ($urandom_range(0, 1) == 1),
           $urandom);
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (q_d.size() > 0) resp($urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates one shared memory bus between two requesters: the instruction-fetch port of IF and the data port that feeds MEM (`dram_rvalid` / `dram_rdata`). It grants at most one request per cycle, round-robin on contention. It keeps a small in-order owner FIFO so each read response is routed back to the requester that issued it. Responses for reads outstanding across an IF flush are discarded. It sits between the core pipeline and the memory/bus fabric.

## Interface
Parameters:
- `OST_DEPTH`, 2, maximum outstanding reads on the bus (power of 2, ≥1).

Ports:
- `clk`  in  1  clock.
- `rst_b`  in  1  reset; synchronous, active-low.
- `ireq_valid`  in  1  instruction read request.
- `ireq_ready`  out  1  instruction request accepted this cycle.
- `ireq_addr`  in  `XLEN`  instruction address.
- `iflush`  in  1  IF flush; drop all outstanding instruction reads.
- `irvalid`  out  1  instruction read data valid.
- `irdata`  out  `XLEN`  instruction read data.
- `dreq_valid`  in  1  data request (read or write).
- `dreq_ready`  out  1  data request accepted this cycle.
- `dreq_write`  in  1  1 = store, 0 = load.
- `dreq_addr`  in  `XLEN`  data address.
- `dreq_wdata`  in  `XLEN`  store data.
- `dreq_wstrb`  in  `XLEN/8`  byte strobes.
- `dram_rvalid`  out  1  load data valid, to MEM.
- `dram_rdata`  out  `XLEN`  load data, to MEM.
- `bus_req`  out  1  bus request.
- `bus_ready`  in  1  bus accepts request.
- `bus_write`, `bus_addr`, `bus_wdata`, `bus_wstrb`  out  1/`XLEN`/`XLEN`/`XLEN/8`  muxed request fields.
- `bus_rvalid`  in  1  read response valid; responses return in order.
- `bus_rdata`  in  `XLEN`  read response data.

## Operation
- Eligibility: a requester is eligible if its valid is high. A read (instruction, or data with `dreq_write`=0) is additionally eligible only if the owner FIFO is not full. Writes ignore FIFO fullness.
- Grant: if exactly one requester is eligible, it wins. If both are eligible, the winner is the one opposite `last_grant`.
- `last_grant` updates only on a completed handshake (`bus_req & bus_ready`). Reset value: I, so data wins the first contention.
- `bus_req` = any eligible requester. Request fields are muxed from the winner. For an instruction request, `bus_write`=0 and `bus_wstrb`=0.
- `ireq_ready` = winner is I & `bus_ready`. `dreq_ready` = winner is D & `bus_ready`.
- Owner FIFO: a read handshake pushes `{owner, drop=0}`. `bus_rvalid` pops the head.
- Response routing, on pop:
  - owner D: `dram_rvalid`=1.
  - owner I with drop=0: `irvalid`=1.
  - owner I with drop=1: discard the response.
  - `irdata` and `dram_rdata` both equal `bus_rdata` unconditionally.
- `iflush`: sets drop=1 on every FIFO entry owned by I, including an entry being pushed the same cycle. The current cycle's popped I response is also suppressed. D entries are untouched.
- Writes are fire-and-forget: there is no response and no FIFO entry.
- `bus_rvalid` with an empty FIFO is a protocol error. The response is dropped, and a simulation assertion fires.

## Timing
- All request-path and response-path outputs are combinational. The arbiter adds zero latency.
- Read latency seen by a requester equals bus latency.
- Reset values, forced for as long as `rst_b`=0:
  - FIFO empty, `last_grant`=I.
  - `irvalid`=`dram_rvalid`=0.
  - `bus_req`=0, `ireq_ready`=`dreq_ready`=0.
- Push and pop in the same cycle: allowed and the count is unchanged. The full check uses the pre-pop count, so a full FIFO blocks reads even in a pop cycle.
- The FIFO pointers wrap modulo `OST_DEPTH`.
- Requesters may hold valid across cycles. The request is consumed only on its ready.

## Structure
- Shared package `mem_bus_pkg`: `owner_e` {OWN_I, OWN_D} and the `owner_entry_t` struct {owner, drop}.
- Sub-module `owner_fifo`: `OST_DEPTH` entries with push, pop, full, empty, head, and a broadcast "mark all I entries drop" input.
- The arbitration and muxing logic stays in the top module.

## Test plan
- Solo traffic: I read 0x100, then D read 0x200. `bus_addr` is 0x100 then 0x200. Responses 0xAAAA and 0xBBBB appear as `irvalid`/`irdata`=0xAAAA, then `dram_rvalid`/`dram_rdata`=0xBBBB.
- Contention: both request continuously with `bus_ready`=1 and `bus_rvalid` returning 1 cycle later. Grants go D, I, D, I. After 4 handshakes the FIFO never exceeds 2 entries.
- Full: with `OST_DEPTH`=2, issue 2 reads with no response. A third read sees `ready`=0. A D write still completes on the bus with `bus_wstrb`=0xF. When one response arrives, the third read is granted the next cycle.
- Flush: I read outstanding, D read outstanding, then `iflush`=1. The I response produces no `irvalid`, and the next response produces `dram_rvalid`=1.
- Backpressure: `bus_ready`=0 for 3 cycles with both valid. Both readies stay 0, `bus_addr` stays stable, and `last_grant` is unchanged.
- Reset mid-flight: 2 reads outstanding, `rst_b`=0 for 1 cycle. FIFO is empty, and a following `bus_rvalid` raises the assertion with no `irvalid`/`dram_rvalid`.
